// File: rtl/key_pkg.sv
// key_pkg: shared key codes, entry FSM state type and key code type
package key_pkg;
  typedef logic [3:0] key_code_t;
  typedef enum logic [1:0] {IDLE, EDIT, HOLD} state_t;
  localparam key_code_t KEY_CLR  = 4'd10;
  localparam key_code_t KEY_BKSP = 4'd11;
  localparam key_code_t KEY_ENT  = 4'd12;
  localparam key_code_t KEY_F1   = 4'd13;
  localparam key_code_t KEY_F2   = 4'd14;
  localparam key_code_t KEY_F3   = 4'd15;
endpackage

// File: rtl/key_onehot_enc.sv
// key_onehot_enc: 16-bit one-hot key strobe to 4-bit code with one-hot/zero flags
module key_onehot_enc
  import key_pkg::*;
(
  input  logic [15:0] v,
  output key_code_t   code,
  output logic        is_one,
  output logic        is_zero
);
  // OR of set-bit indices; only meaningful when is_one
  always_comb begin
    code = '0;
    for (int i = 0; i < 16; i++)
      code = v[i] ? (code | key_code_t'(i)) : code;
  end
  assign is_zero = (v == 16'h0);
  assign is_one  = !is_zero && ((v & (v - 16'd1)) == 16'h0);
endmodule

// File: rtl/key_entry.sv
// key_entry: keypad digit entry FSM with clear/backspace editing and valid/ready hand-off
module key_entry
  import key_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int LW   = $clog2(NDIG + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [15:0]       key_pulse,
  output logic              code_valid,
  output key_code_t         code,
  output logic [4*NDIG-1:0] entry_bcd,
  output logic [LW-1:0]     entry_len,
  output logic              done_valid,
  output logic [4*NDIG-1:0] done_value,
  input  logic              done_ready,
  output logic              err
);
  key_code_t kc;
  logic      is_one;
  logic      is_zero;
  state_t    state;

  key_onehot_enc u_enc (.v(key_pulse), .code(kc), .is_one(is_one), .is_zero(is_zero));

  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state      <= IDLE;
      code_valid <= 1'b0;
      code       <= '0;
      err        <= 1'b0;
      entry_bcd  <= '0;
      entry_len  <= '0;
      done_valid <= 1'b0;
      done_value <= '0;
    end else begin
      code_valid <= 1'b0;
      err        <= 1'b0;
      if (!is_zero && !is_one) err <= 1'b1;
      else if (is_one) begin
        code_valid <= 1'b1;
        code       <= kc;
        if (state == HOLD) err <= 1'b1;
        else if (kc < KEY_CLR) begin
          // leading zeros are swallowed without error
          if (kc != '0 || entry_len != '0) begin
            if (entry_len == LW'(NDIG)) err <= 1'b1;
            else begin
              entry_bcd <= {entry_bcd[4*NDIG-5:0], kc};
              entry_len <= entry_len + LW'(1);
              state     <= EDIT;
            end
          end
        end else if (kc == KEY_BKSP) begin
          if (state == EDIT) begin
            entry_bcd <= {4'h0, entry_bcd[4*NDIG-1:4]};
            entry_len <= entry_len - LW'(1);
            state     <= (entry_len == LW'(1)) ? IDLE : EDIT;
          end
        end else if (kc == KEY_CLR) begin
          entry_bcd <= '0;
          entry_len <= '0;
          state     <= IDLE;
        end else if (kc == KEY_ENT) begin
          if (state == EDIT) begin
            done_value <= entry_bcd;
            done_valid <= 1'b1;
            state      <= HOLD;
          end else err <= 1'b1;
        end
      end
      if (state == HOLD && done_ready) begin
        done_valid <= 1'b0;
        entry_bcd  <= '0;
        entry_len  <= '0;
        state      <= IDLE;
      end
    end
endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry: directed scoreboard bench for key_entry with NDIG=4
module tb_key_entry;
  typedef struct packed {
    logic        cv;
    logic [3:0]  code;
    logic        err;
    logic [15:0] bcd;
    logic [2:0]  len;
    logic        dv;
    logic [15:0] dval;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] key_pulse = '0;
  logic        done_ready = 1'b0;
  logic        code_valid, err, done_valid;
  logic [3:0]  code;
  logic [15:0] entry_bcd, done_value;
  logic [2:0]  entry_len;
  int          checks = 0;
  int          errors = 0;
  int          step_no = 0;
  exp_t        q[$];

  key_entry #(.NDIG(4)) dut (
    .clk(clk), .rstn(rstn), .key_pulse(key_pulse), .code_valid(code_valid), .code(code),
    .entry_bcd(entry_bcd), .entry_len(entry_len), .done_valid(done_valid),
    .done_value(done_value), .done_ready(done_ready), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] kb(input int k);
    logic [15:0] one;
    one = 16'h1;
    return one << k;
  endfunction

  function automatic exp_t mk(input logic cv, input logic [3:0] c, input logic e,
                              input logic [15:0] b, input logic [2:0] l,
                              input logic dv, input logic [15:0] dval);
    return '{cv: cv, code: c, err: e, bcd: b, len: l, dv: dv, dval: dval};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL step %0d %s got %h exp %h", step_no, tag, got, exp);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL step %0d scoreboard empty got 0 exp 1", step_no);
      return;
    end
    e = q.pop_front();
    chk("code_valid", 16'(code_valid), 16'(e.cv));
    chk("code", 16'(code), 16'(e.code));
    chk("err", 16'(err), 16'(e.err));
    chk("entry_bcd", entry_bcd, e.bcd);
    chk("entry_len", 16'(entry_len), 16'(e.len));
    chk("done_valid", 16'(done_valid), 16'(e.dv));
    chk("done_value", done_value, e.dval);
  endtask

  task automatic step(input logic [15:0] kp, input logic rdy, input exp_t e);
    @(negedge clk);
    step_no++;
    key_pulse  = kp;
    done_ready = rdy;
    q.push_back(e);
    @(posedge clk);
    #1;
    key_pulse  = '0;
    done_ready = 1'b0;
    sb_check();
  endtask

  initial begin
    #2;
    q.push_back(mk(0, 0, 0, 16'h0, 0, 0, 16'h0));
    sb_check();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    // entry then ENT, value held while consumer stalls
    step(kb(1), 0, mk(1, 1, 0, 16'h0001, 1, 0, 16'h0));
    step(kb(2), 0, mk(1, 2, 0, 16'h0012, 2, 0, 16'h0));
    step(kb(3), 0, mk(1, 3, 0, 16'h0123, 3, 0, 16'h0));
    step(kb(12), 0, mk(1, 12, 0, 16'h0123, 3, 1, 16'h0123));
    for (int i = 0; i < 20; i++) step(16'h0, 0, mk(0, 12, 0, 16'h0123, 3, 1, 16'h0123));
    step(16'h0, 1, mk(0, 12, 0, 16'h0, 0, 0, 16'h0123));
    // leading zeros and overflow
    step(kb(0), 0, mk(1, 0, 0, 16'h0, 0, 0, 16'h0123));
    step(kb(0), 0, mk(1, 0, 0, 16'h0, 0, 0, 16'h0123));
    step(kb(5), 0, mk(1, 5, 0, 16'h0005, 1, 0, 16'h0123));
    step(kb(6), 0, mk(1, 6, 0, 16'h0056, 2, 0, 16'h0123));
    step(kb(7), 0, mk(1, 7, 0, 16'h0567, 3, 0, 16'h0123));
    step(kb(8), 0, mk(1, 8, 0, 16'h5678, 4, 0, 16'h0123));
    step(kb(9), 0, mk(1, 9, 1, 16'h5678, 4, 0, 16'h0123));
    step(kb(10), 0, mk(1, 10, 0, 16'h0, 0, 0, 16'h0123));
    // backspace editing and ENT in IDLE
    step(kb(4), 0, mk(1, 4, 0, 16'h0004, 1, 0, 16'h0123));
    step(kb(7), 0, mk(1, 7, 0, 16'h0047, 2, 0, 16'h0123));
    step(kb(11), 0, mk(1, 11, 0, 16'h0004, 1, 0, 16'h0123));
    step(kb(11), 0, mk(1, 11, 0, 16'h0, 0, 0, 16'h0123));
    step(kb(11), 0, mk(1, 11, 0, 16'h0, 0, 0, 16'h0123));
    step(kb(12), 0, mk(1, 12, 1, 16'h0, 0, 0, 16'h0123));
    // CLR, multi-hot and function key
    step(kb(9), 0, mk(1, 9, 0, 16'h0009, 1, 0, 16'h0123));
    step(kb(8), 0, mk(1, 8, 0, 16'h0098, 2, 0, 16'h0123));
    step(kb(10), 0, mk(1, 10, 0, 16'h0, 0, 0, 16'h0123));
    step(16'h0003, 0, mk(0, 10, 1, 16'h0, 0, 0, 16'h0123));
    step(kb(14), 0, mk(1, 14, 0, 16'h0, 0, 0, 16'h0123));
    // HOLD blocks all keys, key coincident with acceptance is dropped
    step(kb(5), 0, mk(1, 5, 0, 16'h0005, 1, 0, 16'h0123));
    step(kb(12), 0, mk(1, 12, 0, 16'h0005, 1, 1, 16'h0005));
    step(kb(3), 0, mk(1, 3, 1, 16'h0005, 1, 1, 16'h0005));
    step(kb(10), 0, mk(1, 10, 1, 16'h0005, 1, 1, 16'h0005));
    step(kb(2), 1, mk(1, 2, 1, 16'h0, 0, 0, 16'h0005));
    // asynchronous reset while holding a value
    step(kb(7), 0, mk(1, 7, 0, 16'h0007, 1, 0, 16'h0005));
    step(kb(12), 0, mk(1, 12, 0, 16'h0007, 1, 1, 16'h0007));
    @(negedge clk);
    #2;
    step_no++;
    rstn = 1'b0;
    #1;
    q.push_back(mk(0, 0, 0, 16'h0, 0, 0, 16'h0));
    sb_check();
    @(negedge clk);
    rstn = 1'b1;
    step(kb(6), 0, mk(1, 6, 0, 16'h0006, 1, 0, 16'h0));
    step(16'h0, 0, mk(0, 6, 0, 16'h0006, 1, 0, 16'h0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
